// File: rtl/flipping_pkg.sv
// ============================================================================
// Module : flipping_pkg
// Brief  : Shared types and helpers for the flip-decision pipeline.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package flipping_pkg;

    typedef enum logic [1:0] {
        FLIP_AUTO     = 2'b00,
        FLIP_FORCE0   = 2'b01,
        FLIP_FORCE1   = 2'b10,
        FLIP_AUTO_ALT = 2'b11
    } flip_mode_t;

    localparam int STAT_W = 16;

    // Width needed to hold the popcount of one half of an n-bit word.
    function automatic int cnt_w(input int n);
        return $clog2(n / 2 + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/decisor_flipping_contador_unos.sv
// ============================================================================
// Module : contador_unos
// Brief  : Combinational popcount of a W-bit vector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module contador_unos #(
    parameter int W     = 8,
    parameter int OUT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     i_bits,
    output logic [OUT_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int k = 0; k < W; k++) begin
            o_count = o_count + OUT_W'(i_bits[k]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/decisor_flipping.sv
// ============================================================================
// Module : decisor_flipping
// Brief  : Two-stage valid/ready pipeline deciding the bit-reversal flag per
//          word. Optional counters enabled by macro FLIP_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module decisor_flipping
    import flipping_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_f
`ifdef FLIP_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_words,
    output logic [STAT_W-1:0] stat_flips
`endif
);

    localparam int HALF  = N / 2;
    localparam int CNT_W = cnt_w(N);

    logic [CNT_W-1:0] w_pu;
    logic [CNT_W-1:0] w_pl;
    logic             w_s1_load;
    logic             w_s2_load;
    logic             w_f;

    logic             r_s1_valid;
    logic [N-1:0]     r_s1_word;
    flip_mode_t       r_s1_mode;
    logic [CNT_W-1:0] r_s1_pu;
    logic [CNT_W-1:0] r_s1_pl;

    logic             r_s2_valid;
    logic [N-1:0]     r_s2_word;
    logic             r_s2_f;

    contador_unos #(.W(HALF), .OUT_W(CNT_W)) u_cnt_upper (
        .i_bits  (in_data[N-1:HALF]),
        .o_count (w_pu)
    );

    contador_unos #(.W(HALF), .OUT_W(CNT_W)) u_cnt_lower (
        .i_bits  (in_data[HALF-1:0]),
        .o_count (w_pl)
    );

    // S2 drains into the consumer in the same cycle it refills from S1,
    // which is what keeps a full pipeline streaming at one word per cycle.
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_load = in_valid && in_ready;

    always_comb begin
        w_f = 1'b0;
        case (r_s1_mode)
            FLIP_FORCE0: w_f = 1'b0;
            FLIP_FORCE1: w_f = 1'b1;
            default:     w_f = (r_s1_pu > r_s1_pl);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_word  <= '0;
            r_s1_mode  <= FLIP_AUTO;
            r_s1_pu    <= '0;
            r_s1_pl    <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_word  <= in_data;
                r_s1_mode  <= flip_mode_t'(in_mode);
                r_s1_pu    <= w_pu;
                r_s1_pl    <= w_pl;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_word  <= '0;
            r_s2_f     <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_word  <= r_s1_word;
                r_s2_f     <= w_f;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_word;
    assign out_f     = r_s2_f;

`ifdef FLIP_STATS_EN
    logic              w_out_fire;
    logic [STAT_W-1:0] r_stat_words;
    logic [STAT_W-1:0] r_stat_flips;

    assign w_out_fire = r_s2_valid && out_ready;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_words <= '0;
            r_stat_flips <= '0;
        end else if (w_out_fire) begin
            if (r_stat_words != {STAT_W{1'b1}}) begin
                r_stat_words <= r_stat_words + STAT_W'(1);
            end
            if (r_s2_f && (r_stat_flips != {STAT_W{1'b1}})) begin
                r_stat_flips <= r_stat_flips + STAT_W'(1);
            end
        end
    end

    assign stat_words = r_stat_words;
    assign stat_flips = r_stat_flips;
`endif

endmodule

`default_nettype wire
